// File: rtl/axis_arbiter_pkg.sv
// Shared types and constants for the two-input AXI4-Stream packet arbiter.
package axis_arbiter_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_A = 2'd1,
      LOCK_B = 2'd2
   } arb_state_t;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_t;

endpackage : axis_arbiter_pkg

// File: rtl/axis_reg_slice.sv
// Full-throughput AXI4-Stream register slice: output register plus one skid entry.
// in_ready_o depends only on registered state, breaking the ready path to the sink.
module axis_reg_slice #(
   parameter int DATA_WIDTH = axis_arbiter_pkg::DEFAULT_DATA_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  in_last_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_last_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i
);

   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
   logic                  skid_last_q, skid_last_d;
   logic                  skid_valid_q, skid_valid_d;
   logic                  in_fire;

   assign in_ready_o = !skid_valid_q;
   assign in_fire    = in_valid_i && !skid_valid_q;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      out_data_d   = out_data_q;
      out_last_d   = out_last_q;
      out_valid_d  = out_valid_q;
      skid_data_d  = skid_data_q;
      skid_last_d  = skid_last_q;
      skid_valid_d = skid_valid_q;

      if (!out_valid_q || out_ready_i) begin
         // Output is empty or draining: skid has priority to keep beat order.
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            out_last_d   = skid_last_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            out_data_d  = in_data_i;
            out_last_d  = in_last_i;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_data_d  = in_data_i;
         skid_last_d  = in_last_i;
         skid_valid_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   // NOTE: skid payload is qualified by skid_valid_q, so it needs no reset.
   always_ff @(posedge clk_i) begin
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
   end

   assign out_data_o  = out_data_q;
   assign out_last_o  = out_last_q;
   assign out_valid_o = out_valid_q;

endmodule : axis_reg_slice

// File: rtl/axis_arbiter.sv
// Two-to-one AXI4-Stream packet arbiter: round-robin between packets, grant locked
// until tlast, output fully registered through axis_reg_slice.
module axis_arbiter
   import axis_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  axis_aclk,
   input  logic                  axis_areset,
   input  logic [DATA_WIDTH-1:0] s0a_axis_tdata,
   input  logic                  s0a_axis_tvalid,
   output logic                  s0a_axis_tready,
   input  logic                  s0a_axis_tlast,
   input  logic [DATA_WIDTH-1:0] s0b_axis_tdata,
   input  logic                  s0b_axis_tvalid,
   output logic                  s0b_axis_tready,
   input  logic                  s0b_axis_tlast,
   output logic [DATA_WIDTH-1:0] m0k_axis_tdata,
   output logic                  m0k_axis_tvalid,
   input  logic                  m0k_axis_tready,
   output logic                  m0k_axis_tlast
);

   arb_state_t            state_q, state_d;
   src_t                  last_served_q, last_served_d;
   logic                  grant_a, grant_b;
   logic                  fire_a, fire_b;
   logic                  slice_ready;
   logic                  can_accept;
   logic                  mux_valid;
   logic                  mux_last;
   logic [DATA_WIDTH-1:0] mux_data;

   assign can_accept = slice_ready && !axis_areset;

   always_comb begin
      grant_a       = 1'b0;
      grant_b       = 1'b0;
      state_d       = state_q;
      last_served_d = last_served_q;

      unique case (state_q)
         IDLE: begin
            if (s0a_axis_tvalid && (!s0b_axis_tvalid || last_served_q == SRC_B)) begin
               grant_a = 1'b1;
            end else if (s0b_axis_tvalid) begin
               grant_b = 1'b1;
            end
         end
         LOCK_A:  grant_a = 1'b1;
         LOCK_B:  grant_b = 1'b1;
         default: ;
      endcase

      s0a_axis_tready = grant_a && can_accept;
      s0b_axis_tready = grant_b && can_accept;
      fire_a          = s0a_axis_tready && s0a_axis_tvalid;
      fire_b          = s0b_axis_tready && s0b_axis_tvalid;

      if (fire_a) begin
         state_d = s0a_axis_tlast ? IDLE : LOCK_A;
         if (s0a_axis_tlast) last_served_d = SRC_A;
      end else if (fire_b) begin
         state_d = s0b_axis_tlast ? IDLE : LOCK_B;
         if (s0b_axis_tlast) last_served_d = SRC_B;
      end

      mux_valid = (grant_a && s0a_axis_tvalid) || (grant_b && s0b_axis_tvalid);
      mux_data  = grant_b ? s0b_axis_tdata : s0a_axis_tdata;
      mux_last  = grant_b ? s0b_axis_tlast : s0a_axis_tlast;
   end

   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         state_q       <= IDLE;
         last_served_q <= SRC_B;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
      end
   end

   axis_reg_slice #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_slice (
      .clk_i      (axis_aclk),
      .rst_i      (axis_areset),
      .in_data_i  (mux_data),
      .in_last_i  (mux_last),
      .in_valid_i (mux_valid),
      .in_ready_o (slice_ready),
      .out_data_o (m0k_axis_tdata),
      .out_last_o (m0k_axis_tlast),
      .out_valid_o(m0k_axis_tvalid),
      .out_ready_i(m0k_axis_tready)
   );

endmodule : axis_arbiter

// File: tb/tb_axis_arbiter.sv
// Directed self-checking bench for axis_arbiter: reset, locking, fairness,
// back-pressure, single-beat alternation and mid-packet reset.
module tb_axis_arbiter;
   import axis_arbiter_pkg::*;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          areset;
   logic [DW-1:0] a_data, b_data, m_data;
   logic          a_valid, a_ready, a_last;
   logic          b_valid, b_ready, b_last;
   logic          m_valid, m_ready, m_last;

   int n_cmp = 0;
   int n_err = 0;

   logic [32:0] qa[$];
   logic [32:0] qb[$];
   logic [32:0] exp_q[$];
   logic [32:0] mon_q[$];
   logic        rdy_q[$];
   int          stall_a;

   always #5 clk = ~clk;

   axis_arbiter #(.DATA_WIDTH(DW)) dut (
      .axis_aclk      (clk),
      .axis_areset    (areset),
      .s0a_axis_tdata (a_data),
      .s0a_axis_tvalid(a_valid),
      .s0a_axis_tready(a_ready),
      .s0a_axis_tlast (a_last),
      .s0b_axis_tdata (b_data),
      .s0b_axis_tvalid(b_valid),
      .s0b_axis_tready(b_ready),
      .s0b_axis_tlast (b_last),
      .m0k_axis_tdata (m_data),
      .m0k_axis_tvalid(m_valid),
      .m0k_axis_tready(m_ready),
      .m0k_axis_tlast (m_last)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor: a beat transfers at the next rising edge when valid && ready.
   logic        prev_stall = 1'b0;
   logic [32:0] prev_beat;
   always @(negedge clk) begin
      if (areset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check("stable", {m_valid, m_last, m_data}, {1'b1, prev_beat});
         if (m_valid && m_ready) mon_q.push_back({m_last, m_data});
         prev_stall = m_valid && !m_ready;
         prev_beat  = {m_last, m_data};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      areset  = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
      areset = 1'b0;
   endtask

   task automatic run_streams(input string tag, input int budget);
      int  cyc = 0;
      logic fa, fb;
      stall_a = 0;
      while ((qa.size() != 0 || qb.size() != 0) && cyc < budget) begin
         a_valid = (qa.size() != 0);
         b_valid = (qb.size() != 0);
         if (a_valid) {a_last, a_data} = qa[0];
         if (b_valid) {b_last, b_data} = qb[0];
         m_ready = (rdy_q.size() != 0) ? rdy_q.pop_front() : 1'b1;
         @(negedge clk);
         fa = a_valid && a_ready;
         fb = b_valid && b_ready;
         if (a_valid && !a_ready) stall_a++;
         tick();
         if (fa) void'(qa.pop_front());
         if (fb) void'(qb.pop_front());
         cyc++;
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      m_ready = 1'b1;
      check({tag, "_left"}, 64'(qa.size() + qb.size()), 64'd0);
      repeat (4) tick();
   endtask

   task automatic compare_out(input string tag);
      check({tag, "_count"}, 64'(mon_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("%s_beat%0d", tag, i),
               (i < mon_q.size()) ? 64'(mon_q[i]) : 64'hDEAD_BEEF_DEAD, 64'(exp_q[i]));
      end
   endtask

   initial begin
      areset  = 1'b1;
      a_valid = 1'b1;
      a_data  = 32'h55;
      a_last  = 1'b1;
      b_valid = 1'b0;
      b_data  = '0;
      b_last  = 1'b0;
      m_ready = 1'b1;

      // Reset held with A requesting
      repeat (2) begin
         tick();
         check("rst_a_ready", a_ready, 1'b0);
         check("rst_m_valid", m_valid, 1'b0);
         check("rst_m_data", m_data, '0);
      end
      areset = 1'b0;
      #1;
      check("rel_a_ready", a_ready, 1'b1);
      check("rel_m_valid", m_valid, 1'b0);
      tick();
      a_valid = 1'b0;
      check("first_beat", {m_valid, m_last, m_data}, {1'b1, 1'b1, 32'h55});
      tick();
      check("first_drain", m_valid, 1'b0);

      // Back-to-back stream on A; B requests but must stay blocked while A is locked
      mon_q.delete();
      exp_q.delete();
      b_data = 32'hB0;
      b_last = 1'b1;
      for (int i = 0; i < 10; i++) begin
         a_valid = 1'b1;
         a_data  = i;
         a_last  = 1'b0;
         b_valid = (i > 0);
         #1;
         check("lock_a_ready", a_ready, 1'b1);
         check("lock_b_ready", b_ready, 1'b0);
         if (i > 0) check("lat1", {m_valid, m_data}, {1'b1, 32'(i - 1)});
         exp_q.push_back({1'b0, 32'(i)});
         tick();
      end
      a_valid = 1'b0;
      repeat (2) begin
         #1;
         check("gap_b_ready", b_ready, 1'b0);
         tick();
      end
      a_valid = 1'b1;
      a_data  = 32'hFF;
      a_last  = 1'b1;
      exp_q.push_back({1'b1, 32'hFF});
      tick();
      a_valid = 1'b0;
      #1;
      check("after_a_b_ready", b_ready, 1'b1);
      exp_q.push_back({1'b1, 32'hB0});
      tick();
      b_valid = 1'b0;
      repeat (3) tick();
      compare_out("stream");

      // Fairness: last served is B, so A goes first; second A packet waits for B
      mon_q.delete();
      qa = '{{1'b0, 32'hA0}, {1'b0, 32'hA1}, {1'b1, 32'hA2}, {1'b0, 32'hC0}, {1'b1, 32'hC1}};
      qb = '{{1'b0, 32'hB0}, {1'b1, 32'hB1}};
      exp_q = '{{1'b0, 32'hA0}, {1'b0, 32'hA1}, {1'b1, 32'hA2}, {1'b0, 32'hB0},
                {1'b1, 32'hB1}, {1'b0, 32'hC0}, {1'b1, 32'hC1}};
      run_streams("fair", 50);
      compare_out("fair");

      // Back-pressure on a 4-beat packet
      mon_q.delete();
      qa    = '{{1'b0, 32'h10}, {1'b0, 32'h11}, {1'b0, 32'h12}, {1'b1, 32'h13}};
      rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1};
      exp_q = qa;
      run_streams("bp", 50);
      compare_out("bp");
      check("bp_stalls", 64'(stall_a), 64'd2);

      // Single-beat packets alternate, A first after reset
      apply_reset();
      mon_q.delete();
      qa.delete();
      qb.delete();
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         qa.push_back({1'b1, 32'hA0 + 32'(i)});
         qb.push_back({1'b1, 32'hB0 + 32'(i)});
         exp_q.push_back({1'b1, 32'hA0 + 32'(i)});
         exp_q.push_back({1'b1, 32'hB0 + 32'(i)});
      end
      run_streams("alt", 50);
      compare_out("alt");

      // Reset in the middle of a B packet held in the slice
      mon_q.delete();
      m_ready = 1'b0;
      b_valid = 1'b1;
      b_last  = 1'b0;
      b_data  = 32'h61;
      tick();
      b_data = 32'h62;
      tick();
      check("mid_lock_b", 64'(dut.state_q), 64'(LOCK_B));
      areset = 1'b1;
      tick();
      check("mid_m_valid", m_valid, 1'b0);
      check("mid_state", 64'(dut.state_q), 64'(IDLE));
      check("mid_b_ready", b_ready, 1'b0);
      areset  = 1'b0;
      b_valid = 1'b0;
      m_ready = 1'b1;
      qa      = '{{1'b1, 32'hA7}};
      qb      = '{{1'b1, 32'hB7}};
      exp_q   = '{{1'b1, 32'hA7}, {1'b1, 32'hB7}};
      run_streams("post_rst", 20);
      compare_out("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_axis_arbiter
